rr_arbiter16: RTL and testbench

- Round-robin arbiter that shares one resource among 16 requesters. It uses the 16-bit priority-encoding datapath as its winner-selection core.
- Each requester has one request bit. The arbiter returns a registered one-hot grant and a 4-bit grant index.
- A grant is held until the requester releases it or a hold limit forces preemption.
- It sits in front of any shared tile resource, for example an output mux or bus, that must be time-shared.

---
 rtl/arb_pkg.sv | 20 ++
 rtl/prio_enc16.sv | 23 ++
 rtl/rr_arbiter16.sv | 126 ++++++++++++
 tb/tb_rr_arbiter16.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the 16-way round-robin arbiter.
//   N_REQ      : number of requesters
//   IDX_W      : width of a requester index
//   state_t    : arbiter FSM states
//   mask_below : all bits strictly below a given index
package arb_pkg;

  localparam int unsigned N_REQ = 16;
  localparam int unsigned IDX_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] mask_below(input logic [IDX_W-1:0] idx);
    return (N_REQ'(1) << idx) - N_REQ'(1);
  endfunction

endpackage

// File: rtl/prio_enc16.sv
// 16-bit priority encoder, highest set bit wins.
//   i_vec   : input vector
//   o_idx   : index of the highest set bit (0 when i_vec is zero)
//   o_valid : any bit of i_vec set
module prio_enc16
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  // Ascending scan: later (higher) hits overwrite earlier ones.
  always_comb begin
    o_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (i_vec[i]) o_idx = IDX_W'(i);
    end
  end

  assign o_valid = |i_vec;

endmodule

// File: rtl/rr_arbiter16.sv
// Round-robin arbiter sharing one resource among 16 requesters.
// Descending priority, rotating below the last winner; grants are held
// until released or until MAX_HOLD consecutive cycles force preemption.
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   en        : arbitration enable (only consulted when idle)
//   req       : request bits, one per requester
//   gnt       : registered one-hot grant
//   gnt_idx   : index of granted requester, 0 when no grant
//   gnt_valid : any grant active
//   preempt   : one-cycle pulse after a forced release
module rr_arbiter16
  import arb_pkg::*;
#(
  parameter int unsigned N        = 16,
  parameter int unsigned IDXW     = 4,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_valid,
  output logic            preempt
);

  localparam int unsigned       HOLD_W   = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);

  state_t            r_state, w_state;
  logic [N-1:0]      r_gnt, w_gnt;
  logic [IDXW-1:0]   r_idx, w_idx;
  logic [IDXW-1:0]   r_last, w_last;
  logic [HOLD_W-1:0] r_hold, w_hold;
  logic              r_preempt, w_preempt;

  logic [N-1:0]      w_req_masked;
  logic [IDXW-1:0]   w_m_idx, w_u_idx, w_win;
  logic              w_m_valid, w_u_valid;
  logic              w_cur_req, w_limit;

  // Only requesters below the last winner compete in the masked pass.
  assign w_req_masked = req & mask_below(r_last);

  prio_enc16 u_enc_masked (
    .i_vec   (w_req_masked),
    .o_idx   (w_m_idx),
    .o_valid (w_m_valid)
  );

  prio_enc16 u_enc_all (
    .i_vec   (req),
    .o_idx   (w_u_idx),
    .o_valid (w_u_valid)
  );

  assign w_win     = w_m_valid ? w_m_idx : w_u_idx;
  assign w_cur_req = req[r_idx];
  assign w_limit   = (MAX_HOLD != 0) && (r_hold == HOLD_LIM);

  always_comb begin
    w_state   = r_state;
    w_gnt     = r_gnt;
    w_idx     = r_idx;
    w_last    = r_last;
    w_hold    = r_hold;
    w_preempt = 1'b0;
    case (r_state)
      IDLE: begin
        if (en && w_u_valid) begin
          w_state = GRANT;
          w_gnt   = N'(1) << w_win;
          w_idx   = w_win;
          w_last  = w_win;
          w_hold  = HOLD_W'(1);
        end else begin
          w_gnt = '0;
          w_idx = '0;
        end
      end
      GRANT: begin
        if (!w_cur_req || w_limit) begin
          w_state   = IDLE;
          w_gnt     = '0;
          w_idx     = '0;
          // A drop coinciding with the limit is voluntary: only pulse
          // when the owner still wanted the resource.
          w_preempt = w_cur_req;
        end else if ((MAX_HOLD != 0) && (r_hold != HOLD_LIM)) begin
          w_hold = r_hold + HOLD_W'(1);
        end
      end
      default: begin
        w_state = IDLE;
        w_gnt   = '0;
        w_idx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_idx     <= '0;
      r_last    <= '0;
      r_hold    <= '0;
      r_preempt <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_gnt     <= w_gnt;
      r_idx     <= w_idx;
      r_last    <= w_last;
      r_hold    <= w_hold;
      r_preempt <= w_preempt;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_idx   = r_idx;
  assign gnt_valid = |r_gnt;
  assign preempt   = r_preempt;

endmodule

// File: tb/tb_rr_arbiter16.sv
module tb_rr_arbiter16;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [15:0] req;
  logic [15:0] gnt_a, gnt_b;
  logic [3:0]  idx_a, idx_b;
  logic        val_a, val_b, pre_a, pre_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Instance A: hold limit 4. Instance B: unlimited hold.
  rr_arbiter16 #(.N(16), .IDXW(4), .MAX_HOLD(4)) u_a (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .gnt(gnt_a), .gnt_idx(idx_a), .gnt_valid(val_a), .preempt(pre_a)
  );

  rr_arbiter16 #(.N(16), .IDXW(4), .MAX_HOLD(0)) u_b (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .gnt(gnt_b), .gnt_idx(idx_b), .gnt_valid(val_b), .preempt(pre_b)
  );

  typedef struct {
    logic [15:0] g;
    logic [3:0]  i;
    logic        v;
    logic        p;
  } exp_t;

  typedef struct {
    exp_t a;
    exp_t b;
  } sb_t;

  sb_t  sb[$];
  exp_t ea, eb;
  bit   sb_ok;

  // Reference model state, index 0 = instance A, 1 = instance B.
  bit m_busy[2] = '{0, 0};
  int m_idx[2]  = '{0, 0};
  int m_last[2] = '{0, 0};
  int m_hold[2] = '{0, 0};
  bit m_pre[2]  = '{0, 0};
  int mh[2]     = '{4, 0};

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 0; m_idx[k] = 0; m_last[k] = 0; m_hold[k] = 0; m_pre[k] = 0;
    end
    sb.delete();
  endtask

  function automatic exp_t m_out(int k);
    exp_t o;
    o.v = m_busy[k];
    o.i = m_busy[k] ? 4'(m_idx[k]) : 4'd0;
    o.g = m_busy[k] ? (16'h1 << m_idx[k]) : 16'h0;
    o.p = m_pre[k];
    return o;
  endfunction

  // Advance the model by one clock using the inputs now being driven.
  task automatic model_step();
    int w;
    sb_t e;
    for (int k = 0; k < 2; k++) begin
      m_pre[k] = 0;
      if (!m_busy[k]) begin
        if (en && req != 16'h0) begin
          w = -1;
          for (int i = m_last[k] - 1; i >= 0; i--) if (req[i] && w < 0) w = i;
          if (w < 0) for (int i = 15; i >= 0; i--) if (req[i] && w < 0) w = i;
          m_busy[k] = 1; m_idx[k] = w; m_last[k] = w; m_hold[k] = 1;
        end
      end else begin
        if (!req[m_idx[k]]) m_busy[k] = 0;
        else if (mh[k] != 0 && m_hold[k] == mh[k]) begin
          m_busy[k] = 0;
          m_pre[k]  = 1;
        end else m_hold[k]++;
      end
    end
    e.a = m_out(0);
    e.b = m_out(1);
    sb.push_back(e);
  endtask

  task automatic tick();
    sb_t e;
    model_step();
    @(posedge clk); #1;
    sb_ok = (sb.size() > 0);
    if (sb_ok) begin
      e  = sb.pop_front();
      ea = e.a;
      eb = e.b;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    en = 1'b1; req = 16'h0010;
    rst = 1'b1; model_reset(); #1;
    checks++;
    if ({gnt_a, idx_a, val_a, pre_a} !== 22'h0) begin
      failures++;
      $display("FAIL reset_state got gnt=%h idx=%0d v=%b p=%b exp all zero", gnt_a, idx_a, val_a, pre_a);
    end
    @(posedge clk); #1; rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (!sb_ok || {gnt_a, idx_a, val_a, pre_a} !== {ea.g, ea.i, ea.v, ea.p}) begin
        failures++;
        $display("FAIL reset_seq c=%0d got gnt=%h idx=%0d v=%b p=%b exp gnt=%h idx=%0d v=%b p=%b",
                 c, gnt_a, idx_a, val_a, pre_a, ea.g, ea.i, ea.v, ea.p);
      end
    end
    checks++;
    if (gnt_a !== 16'h0010 || idx_a !== 4'd4 || val_a !== 1'b1) begin
      failures++;
      $display("FAIL first_grant got gnt=%h idx=%0d v=%b exp gnt=0010 idx=4 v=1", gnt_a, idx_a, val_a);
    end
    rst = 1'b1; model_reset(); #1;
    checks++;
    if (gnt_a !== 16'h0 || val_a !== 1'b0 || gnt_b !== 16'h0) begin
      failures++;
      $display("FAIL mid_reset got gnt_a=%h v=%b gnt_b=%h exp 0000 0 0000", gnt_a, val_a, gnt_b);
    end
    @(posedge clk); #1; rst = 1'b0;
    req = 16'h0111;
    tick();
    checks++;
    if (!sb_ok || gnt_a !== 16'h0100 || {gnt_a, idx_a, val_a, pre_a} !== {ea.g, ea.i, ea.v, ea.p}) begin
      failures++;
      $display("FAIL post_reset_grant got gnt=%h idx=%0d exp gnt=0100 idx=8", gnt_a, idx_a);
    end
  endtask

  task automatic test_preempt();
    logic [15:0] eg[11] = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h0000,
                            16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0000, 16'h8000};
    bit ep;
    en = 1'b1; req = 16'h8001;
    do_reset();
    for (int c = 0; c < 11; c++) begin
      tick();
      ep = (c == 4) || (c == 9);
      checks++;
      if (!sb_ok || {gnt_a, idx_a, val_a, pre_a} !== {ea.g, ea.i, ea.v, ea.p}) begin
        failures++;
        $display("FAIL preempt_model c=%0d got gnt=%h idx=%0d v=%b p=%b exp gnt=%h idx=%0d v=%b p=%b",
                 c, gnt_a, idx_a, val_a, pre_a, ea.g, ea.i, ea.v, ea.p);
      end
      checks++;
      if (gnt_a !== eg[c] || pre_a !== ep) begin
        failures++;
        $display("FAIL preempt_table c=%0d got gnt=%h p=%b exp gnt=%h p=%b", c, gnt_a, pre_a, eg[c], ep);
      end
    end
  endtask

  task automatic test_voluntary();
    logic [3:0] exp_order[5] = '{4'd11, 4'd10, 4'd9, 4'd8, 4'd11};
    logic [3:0] order[$];
    bit ok;
    en = 1'b1; req = 16'h0F00;
    do_reset();
    for (int c = 1; c <= 14; c++) begin
      tick();
      checks++;
      if (!sb_ok || {gnt_a, idx_a, val_a, pre_a} !== {ea.g, ea.i, ea.v, ea.p} || pre_a !== 1'b0) begin
        failures++;
        $display("FAIL voluntary_model c=%0d got gnt=%h idx=%0d v=%b p=%b exp gnt=%h idx=%0d v=%b p=0",
                 c, gnt_a, idx_a, val_a, pre_a, ea.g, ea.i, ea.v);
      end
      if (val_a && (c % 3 == 1)) order.push_back(idx_a);
      if (c % 3 == 2) req = 16'h0F00 & ~(16'h1 << ea.i);
      else            req = 16'h0F00;
    end
    ok = (order.size() == 5);
    if (ok) for (int i = 0; i < 5; i++) if (order[i] !== exp_order[i]) ok = 0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL voluntary_order got %p exp 11 10 9 8 11", order);
    end
  endtask

  task automatic test_wrap_below();
    en = 1'b1; req = 16'h0020;
    do_reset();
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++;
      if (!sb_ok || {gnt_a, idx_a, val_a, pre_a} !== {ea.g, ea.i, ea.v, ea.p}) begin
        failures++;
        $display("FAIL wrap_model c=%0d got gnt=%h idx=%0d v=%b p=%b exp gnt=%h idx=%0d v=%b p=%b",
                 c, gnt_a, idx_a, val_a, pre_a, ea.g, ea.i, ea.v, ea.p);
      end
      if (c == 1) req = 16'h0061;
      if (c == 2) req = 16'h0041;
      if (c == 3) begin
        checks++;
        if (gnt_a !== 16'h0 || pre_a !== 1'b0) begin
          failures++;
          $display("FAIL wrap_gap got gnt=%h p=%b exp gnt=0000 p=0", gnt_a, pre_a);
        end
      end
    end
    checks++;
    if (gnt_a !== 16'h0001 || idx_a !== 4'd0 || pre_a !== 1'b0) begin
      failures++;
      $display("FAIL wrap_below got gnt=%h idx=%0d p=%b exp gnt=0001 idx=0 p=0", gnt_a, idx_a, pre_a);
    end
  endtask

  task automatic test_enable();
    logic [15:0] eg[7] = '{16'h0, 16'h0, 16'h0, 16'h8000, 16'h8000, 16'h0, 16'h0};
    en = 1'b0; req = 16'hFFFF;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      tick();
      checks++;
      if (!sb_ok || {gnt_a, idx_a, val_a, pre_a} !== {ea.g, ea.i, ea.v, ea.p}) begin
        failures++;
        $display("FAIL enable_model c=%0d got gnt=%h idx=%0d v=%b p=%b exp gnt=%h idx=%0d v=%b p=%b",
                 c, gnt_a, idx_a, val_a, pre_a, ea.g, ea.i, ea.v, ea.p);
      end
      checks++;
      if (gnt_a !== eg[c]) begin
        failures++;
        $display("FAIL enable_table c=%0d got gnt=%h exp gnt=%h", c, gnt_a, eg[c]);
      end
      if (c == 2) en = 1'b1;
      if (c == 3) en = 1'b0;
      if (c == 4) req = 16'h7FFF;
    end
  endtask

  task automatic test_unlimited();
    en = 1'b1; req = 16'h0004;
    do_reset();
    for (int c = 0; c < 100; c++) begin
      tick();
      checks++;
      if (gnt_b !== 16'h0004 || idx_b !== 4'd2 || pre_b !== 1'b0 ||
          !sb_ok || {gnt_b, idx_b, val_b, pre_b} !== {eb.g, eb.i, eb.v, eb.p}) begin
        failures++;
        $display("FAIL unlimited_b c=%0d got gnt=%h idx=%0d p=%b exp gnt=0004 idx=2 p=0", c, gnt_b, idx_b, pre_b);
      end
      checks++;
      if (!sb_ok || {gnt_a, idx_a, val_a, pre_a} !== {ea.g, ea.i, ea.v, ea.p}) begin
        failures++;
        $display("FAIL unlimited_a c=%0d got gnt=%h idx=%0d v=%b p=%b exp gnt=%h idx=%0d v=%b p=%b",
                 c, gnt_a, idx_a, val_a, pre_a, ea.g, ea.i, ea.v, ea.p);
      end
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; req = 16'h0;
    #2;
    test_reset();
    test_preempt();
    test_voluntary();
    test_wrap_below();
    test_enable();
    test_unlimited();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
